// File: rtl/vend_core.sv
// vend_core: single-customer vending controller with per-slot stock and cost.
//   Inputs : clk, hrst_n (async, active-low), sel_valid/sel_idx (selection),
//            coin_valid/coin (01=5, 10=10, 11=25, 00 invalid), cancel,
//            restock_valid/restock_idx/restock_count, restock_cost_valid/restock_cost.
//   Outputs: status (0 none, 1 avail, 2 oos, 3 err, 4 cancelled, 5 timeout),
//            price, amount, dispense_valid/dispense_idx, change_valid/change_amt,
//            coin_reject. All outputs come straight from flops.

// Per-slot stock counter and cost register.
module vend_slot #(
  parameter int CNT_W    = 5,
  parameter int AMT_W    = 16,
  parameter int DEF_COST = 100
) (
  input  logic             clk,
  input  logic             hrst_n,
  input  logic             add_en,
  input  logic [CNT_W-1:0] add_cnt,
  input  logic             dec_en,
  input  logic             cost_en,
  input  logic [AMT_W-1:0] cost_in,
  output logic [CNT_W-1:0] stock,
  output logic [AMT_W-1:0] cost
);
  logic [CNT_W-1:0] stock_q, stock_d;
  logic [AMT_W-1:0] cost_q, cost_d;

  // add and dec are never both set: restock only runs in IDLE/RESTOCK, dec only in DISPENSE
  always_comb begin
    stock_d = stock_q;
    cost_d  = cost_q;
    if (add_en)      stock_d = stock_q + add_cnt;
    else if (dec_en) stock_d = stock_q - CNT_W'(1);
    if (cost_en)     cost_d  = cost_in;
  end

  always_ff @(posedge clk or negedge hrst_n) begin
    if (!hrst_n) begin
      stock_q <= '0;
      cost_q  <= AMT_W'(DEF_COST);
    end else begin
      stock_q <= stock_d;
      cost_q  <= cost_d;
    end
  end

  assign stock = stock_q;
  assign cost  = cost_q;
endmodule

module vend_core #(
  parameter int N_ITEMS     = 8,
  parameter int CNT_W       = 5,
  parameter int MAX_STOCK   = 16,
  parameter int AMT_W       = 16,
  parameter int DEF_COST    = 100,
  parameter int TIMEOUT_CYC = 255,
  localparam int IDX_W      = $clog2(N_ITEMS)
) (
  input  logic             clk,
  input  logic             hrst_n,
  input  logic             sel_valid,
  input  logic [IDX_W-1:0] sel_idx,
  input  logic             coin_valid,
  input  logic [1:0]       coin,
  input  logic             cancel,
  input  logic             restock_valid,
  input  logic [IDX_W-1:0] restock_idx,
  input  logic [CNT_W-1:0] restock_count,
  input  logic             restock_cost_valid,
  input  logic [AMT_W-1:0] restock_cost,
  output logic [2:0]       status,
  output logic [AMT_W-1:0] price,
  output logic [AMT_W-1:0] amount,
  output logic             dispense_valid,
  output logic [IDX_W-1:0] dispense_idx,
  output logic             change_valid,
  output logic [AMT_W-1:0] change_amt,
  output logic             coin_reject
);
  localparam int            TW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W:0] N_L   = (IDX_W+1)'(N_ITEMS);
  localparam logic [CNT_W:0] MAX_L = (CNT_W+1)'(MAX_STOCK);
  localparam logic [TW-1:0]  TO_L  = TW'(TIMEOUT_CYC);

  typedef enum logic [5:0] {
    S_IDLE     = 6'b000001,
    S_CHECK    = 6'b000010,
    S_COLLECT  = 6'b000100,
    S_DISPENSE = 6'b001000,
    S_REFUND   = 6'b010000,
    S_RESTOCK  = 6'b100000
  } state_t;

  typedef enum logic [2:0] {
    ST_NONE, ST_AVAIL, ST_OOS, ST_ERR, ST_CANCEL, ST_TIMEOUT
  } status_t;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             cost_vld;
    logic [AMT_W-1:0] cost;
  } rs_req_t;

  state_t           state_q, state_d;
  status_t          status_q, status_d;
  logic [IDX_W-1:0] idx_q, idx_d, dispense_idx_q, dispense_idx_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [AMT_W-1:0] amount_q, amount_d, price_q, price_d, change_amt_q, change_amt_d;
  logic             dispense_valid_q, dispense_valid_d;
  logic             change_valid_q, change_valid_d;
  logic             coin_reject_q, coin_reject_d;

  logic [N_ITEMS-1:0][CNT_W-1:0] stock_w;
  logic [N_ITEMS-1:0][AMT_W-1:0] cost_w;

  rs_req_t rs;
  assign rs = '{vld: restock_valid, idx: restock_idx, cnt: restock_count,
                cost_vld: restock_cost_valid, cost: restock_cost};

  // Slot lookups by the restock index and by the latched selection.
  logic [CNT_W-1:0] rs_stock, sel_stock;
  logic [AMT_W-1:0] sel_cost;
  always_comb begin
    rs_stock  = '0;
    sel_stock = '0;
    sel_cost  = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (rs.idx == IDX_W'(i)) rs_stock = stock_w[i];
      if (idx_q == IDX_W'(i)) begin
        sel_stock = stock_w[i];
        sel_cost  = cost_w[i];
      end
    end
  end

  // The restock beat that moves IDLE into RESTOCK is applied too, so a single
  // restock_valid cycle performs exactly one update.
  logic           rs_beat, rs_idx_ok, rs_fit, rs_stock_en, rs_cost_en, rs_err;
  logic [CNT_W:0] rs_sum;
  assign rs_beat     = rs.vld && (state_q == S_IDLE || state_q == S_RESTOCK);
  assign rs_idx_ok   = {1'b0, rs.idx} < N_L;
  assign rs_sum      = {1'b0, rs_stock} + {1'b0, rs.cnt};
  assign rs_fit      = rs_sum <= MAX_L;
  assign rs_stock_en = rs_beat && rs_idx_ok && rs_fit;
  assign rs_cost_en  = rs_beat && rs_idx_ok && rs.cost_vld;
  assign rs_err      = rs_beat && !(rs_idx_ok && rs_fit);

  for (genvar g = 0; g < N_ITEMS; g++) begin : g_slot
    vend_slot #(.CNT_W(CNT_W), .AMT_W(AMT_W), .DEF_COST(DEF_COST)) u_slot (
      .clk     (clk),
      .hrst_n  (hrst_n),
      .add_en  (rs_stock_en && rs.idx == IDX_W'(g)),
      .add_cnt (rs.cnt),
      .dec_en  (state_q == S_DISPENSE && idx_q == IDX_W'(g)),
      .cost_en (rs_cost_en && rs.idx == IDX_W'(g)),
      .cost_in (rs.cost),
      .stock   (stock_w[g]),
      .cost    (cost_w[g])
    );
  end

  // Coin crediting with saturation at the top of the amount range.
  logic [AMT_W-1:0] coin_val, amt_add, amt_new;
  logic [AMT_W:0]   amt_sum;
  logic             coin_ok;
  always_comb begin
    case (coin)
      2'b01:   coin_val = AMT_W'(5);
      2'b10:   coin_val = AMT_W'(10);
      2'b11:   coin_val = AMT_W'(25);
      default: coin_val = '0;
    endcase
  end
  assign coin_ok = coin_valid && (coin != 2'b00);
  assign amt_sum = {1'b0, amount_q} + {1'b0, coin_val};
  assign amt_add = amt_sum[AMT_W] ? '1 : amt_sum[AMT_W-1:0];
  assign amt_new = coin_ok ? amt_add : amount_q;

  always_comb begin
    state_d          = state_q;
    status_d         = status_q;
    idx_d            = idx_q;
    timer_d          = timer_q;
    amount_d         = amount_q;
    price_d          = price_q;
    change_amt_d     = change_amt_q;
    dispense_idx_d   = dispense_idx_q;
    dispense_valid_d = 1'b0;
    change_valid_d   = 1'b0;
    coin_reject_d    = coin_valid && !(state_q == S_COLLECT && coin != 2'b00);
    case (state_q)
      S_IDLE: begin
        if (rs.vld) begin
          state_d = S_RESTOCK;
          if (rs_err) status_d = ST_ERR;
        end else if (sel_valid) begin
          if ({1'b0, sel_idx} < N_L) begin
            idx_d   = sel_idx;
            state_d = S_CHECK;
          end else begin
            status_d = ST_ERR;
          end
        end
      end
      S_CHECK: begin
        if (sel_stock == '0) begin
          status_d = ST_OOS;
          state_d  = S_IDLE;
        end else begin
          status_d = ST_AVAIL;
          price_d  = sel_cost;
          timer_d  = TO_L;
          state_d  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // A coin arriving with cancel is credited, then refunded in full.
        amount_d = amt_new;
        if (cancel) begin
          status_d = ST_CANCEL;
          state_d  = S_REFUND;
        end else if (amt_new >= price_q) begin
          state_d = S_DISPENSE;
        end else if (coin_ok) begin
          timer_d = TO_L;
        end else if (timer_q == '0) begin
          status_d = ST_TIMEOUT;
          state_d  = S_REFUND;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_DISPENSE: begin
        dispense_valid_d = 1'b1;
        dispense_idx_d   = idx_q;
        change_valid_d   = 1'b1;
        change_amt_d     = amount_q - price_q;
        amount_d         = '0;
        state_d          = S_IDLE;
      end
      S_REFUND: begin
        if (amount_q != '0) begin
          change_valid_d = 1'b1;
          change_amt_d   = amount_q;
        end
        amount_d = '0;
        state_d  = S_IDLE;
      end
      S_RESTOCK: begin
        if (!rs.vld)    state_d  = S_IDLE;
        else if (rs_err) status_d = ST_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge hrst_n) begin
    if (!hrst_n) begin
      state_q          <= S_IDLE;
      status_q         <= ST_NONE;
      idx_q            <= '0;
      timer_q          <= '0;
      amount_q         <= '0;
      price_q          <= '0;
      change_amt_q     <= '0;
      dispense_idx_q   <= '0;
      dispense_valid_q <= 1'b0;
      change_valid_q   <= 1'b0;
      coin_reject_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      status_q         <= status_d;
      idx_q            <= idx_d;
      timer_q          <= timer_d;
      amount_q         <= amount_d;
      price_q          <= price_d;
      change_amt_q     <= change_amt_d;
      dispense_idx_q   <= dispense_idx_d;
      dispense_valid_q <= dispense_valid_d;
      change_valid_q   <= change_valid_d;
      coin_reject_q    <= coin_reject_d;
    end
  end

  assign status         = status_q;
  assign price          = price_q;
  assign amount         = amount_q;
  assign dispense_valid = dispense_valid_q;
  assign dispense_idx   = dispense_idx_q;
  assign change_valid   = change_valid_q;
  assign change_amt     = change_amt_q;
  assign coin_reject    = coin_reject_q;
endmodule

// File: tb/tb_vend_core.sv
// tb_vend_core: scenario tasks plus randomized purchases/restocks checked
// against a slot-level reference model (stock/cost arrays, coin sums).
module tb_vend_core;
  localparam int N_ITEMS = 6, CNT_W = 5, MAX_STOCK = 16, AMT_W = 16;
  localparam int DEF_COST = 100, TIMEOUT_CYC = 40;
  localparam int IDX_W = $clog2(N_ITEMS);

  logic             clk = 1'b0, hrst_n = 1'b0;
  logic             sel_valid = 1'b0, coin_valid = 1'b0, cancel = 1'b0;
  logic [IDX_W-1:0] sel_idx = '0, restock_idx = '0;
  logic [1:0]       coin = '0;
  logic             restock_valid = 1'b0, restock_cost_valid = 1'b0;
  logic [CNT_W-1:0] restock_count = '0;
  logic [AMT_W-1:0] restock_cost = '0;
  logic [2:0]       status;
  logic [AMT_W-1:0] price, amount, change_amt;
  logic             dispense_valid, change_valid, coin_reject;
  logic [IDX_W-1:0] dispense_idx;

  vend_core #(.N_ITEMS(N_ITEMS), .CNT_W(CNT_W), .MAX_STOCK(MAX_STOCK), .AMT_W(AMT_W),
              .DEF_COST(DEF_COST), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .hrst_n(hrst_n), .sel_valid(sel_valid), .sel_idx(sel_idx),
    .coin_valid(coin_valid), .coin(coin), .cancel(cancel),
    .restock_valid(restock_valid), .restock_idx(restock_idx), .restock_count(restock_count),
    .restock_cost_valid(restock_cost_valid), .restock_cost(restock_cost),
    .status(status), .price(price), .amount(amount),
    .dispense_valid(dispense_valid), .dispense_idx(dispense_idx),
    .change_valid(change_valid), .change_amt(change_amt), .coin_reject(coin_reject));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int m_stock[8], m_cost[8], m_status;
  int exp_disp = 0, seen_disp = 0, pulse_bad = 0;
  logic prev_dv = 1'b0, prev_cv = 1'b0;

  // Pulse monitor: dispense/change must never be high on two consecutive cycles.
  always @(negedge clk) begin
    if (!hrst_n) begin
      prev_dv = 1'b0; prev_cv = 1'b0;
    end else begin
      if ((dispense_valid && prev_dv) || (change_valid && prev_cv)) pulse_bad++;
      if (dispense_valid) seen_disp++;
      prev_dv = dispense_valid; prev_cv = change_valid;
    end
  end

  // ---------------- reference model ----------------
  function automatic void m_reset();
    for (int i = 0; i < 8; i++) begin m_stock[i] = 0; m_cost[i] = DEF_COST; end
    m_status = 0;
  endfunction

  // Returns 1 when the restock must be flagged as an error.
  function automatic bit m_restock(int idx, int cnt, bit cv, int cst);
    if (idx >= N_ITEMS) return 1'b1;
    if (cv) m_cost[idx] = cst;
    if (m_stock[idx] + cnt > MAX_STOCK) return 1'b1;
    m_stock[idx] += cnt;
    return 1'b0;
  endfunction

  function automatic int coin_value(int code);
    case (code)
      1: return 5;
      2: return 10;
      3: return 25;
      default: return 0;
    endcase
  endfunction

  // ---------------- stimulus drivers ----------------
  task automatic tick(); @(posedge clk); #1; endtask

  task automatic do_restock(input int idx, input int cnt, input bit cv, input int cst);
    restock_valid = 1'b1; restock_idx = IDX_W'(idx); restock_count = CNT_W'(cnt);
    restock_cost_valid = cv; restock_cost = AMT_W'(cst);
    tick();
    restock_valid = 1'b0; restock_cost_valid = 1'b0;
    tick();
  endtask

  task automatic do_select(input int idx);
    sel_valid = 1'b1; sel_idx = IDX_W'(idx);
    tick();
    sel_valid = 1'b0;
    tick();
  endtask

  task automatic coin_in(input logic [1:0] code);
    coin_valid = 1'b1; coin = code;
    tick();
    coin_valid = 1'b0; coin = 2'b00;
  endtask

  // Select then cancel with no credit: leaves status CANCELLED, no change pulse.
  task automatic mark_status(input int idx);
    do_select(idx);
    cancel = 1'b1; tick(); cancel = 1'b0; tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    m_reset();
    tick(); tick();
    checks++; if (status !== 3'd0) begin failures++; $display("FAIL reset_status got=%0d exp=0", status); end
    checks++; if (amount !== '0) begin failures++; $display("FAIL reset_amount got=%0d exp=0", amount); end
    checks++; if (price !== '0) begin failures++; $display("FAIL reset_price got=%0d exp=0", price); end
    checks++; if (change_amt !== '0) begin failures++; $display("FAIL reset_change_amt got=%0d exp=0", change_amt); end
    checks++; if ({dispense_valid, change_valid, coin_reject} !== 3'b000) begin
      failures++; $display("FAIL reset_pulses got=%b exp=000", {dispense_valid, change_valid, coin_reject}); end
    hrst_n = 1'b1;
    tick();
    checks++; if (status !== 3'd0) begin failures++; $display("FAIL post_reset_status got=%0d exp=0", status); end
    coin_in(2'b11);
    checks++; if (coin_reject !== 1'b1) begin failures++; $display("FAIL idle_coin_reject got=%b exp=1", coin_reject); end
    tick();
    checks++; if (coin_reject !== 1'b0) begin failures++; $display("FAIL reject_width got=%b exp=0", coin_reject); end
  endtask

  task automatic test_restock_vend();
    bit err;
    err = m_restock(2, 3, 1'b1, 60);
    do_restock(2, 3, 1'b1, 60);
    checks++; if (status !== 3'(err ? 3 : m_status)) begin failures++; $display("FAIL rs2_status got=%0d exp=%0d", status, err ? 3 : m_status); end
    for (int k = 0; k < 3; k++) begin
      do_select(2);
      checks++; if (status !== 3'd1) begin failures++; $display("FAIL buy2_status[%0d] got=%0d exp=1", k, status); end
      checks++; if (price !== AMT_W'(m_cost[2])) begin failures++; $display("FAIL buy2_price[%0d] got=%0d exp=%0d", k, price, m_cost[2]); end
      coin_in(2'b11); coin_in(2'b11); coin_in(2'b10);
      checks++; if (amount !== AMT_W'(60)) begin failures++; $display("FAIL buy2_amount[%0d] got=%0d exp=60", k, amount); end
      tick();
      checks++; if (dispense_valid !== 1'b1 || dispense_idx !== IDX_W'(2)) begin
        failures++; $display("FAIL buy2_dispense[%0d] got=%b/%0d exp=1/2", k, dispense_valid, dispense_idx); end
      checks++; if (change_valid !== 1'b1 || change_amt !== '0) begin
        failures++; $display("FAIL buy2_change[%0d] got=%b/%0d exp=1/0", k, change_valid, change_amt); end
      checks++; if (amount !== '0) begin failures++; $display("FAIL buy2_clear[%0d] got=%0d exp=0", k, amount); end
      m_stock[2]--; exp_disp++; m_status = 1;
    end
    do_select(2);
    m_status = 2;
    checks++; if (status !== 3'd2) begin failures++; $display("FAIL slot2_empty got=%0d exp=2", status); end
  endtask

  task automatic test_overpay();
    void'(m_restock(3, 2, 1'b1, 60));
    do_restock(3, 2, 1'b1, 60);
    do_select(3);
    coin_in(2'b11); coin_in(2'b11); coin_in(2'b11);
    checks++; if (amount !== AMT_W'(75)) begin failures++; $display("FAIL overpay_amount got=%0d exp=75", amount); end
    tick();
    checks++; if (dispense_valid !== 1'b1 || dispense_idx !== IDX_W'(3)) begin
      failures++; $display("FAIL overpay_dispense got=%b/%0d exp=1/3", dispense_valid, dispense_idx); end
    checks++; if (change_valid !== 1'b1 || change_amt !== AMT_W'(15)) begin
      failures++; $display("FAIL overpay_change got=%b/%0d exp=1/15", change_valid, change_amt); end
    m_stock[3]--; exp_disp++; m_status = 1;
  endtask

  task automatic test_timeout();
    int n = 0;
    do_select(3);
    coin_in(2'b10);
    checks++; if (amount !== AMT_W'(10)) begin failures++; $display("FAIL to_amount got=%0d exp=10", amount); end
    while (change_valid !== 1'b1 && n < TIMEOUT_CYC + 10) begin tick(); n++; end
    checks++; if (change_valid !== 1'b1) begin failures++; $display("FAIL to_no_refund got=%b exp=1 after %0d cycles", change_valid, n); end
    checks++; if (n < TIMEOUT_CYC || n > TIMEOUT_CYC + 3) begin
      failures++; $display("FAIL to_latency got=%0d exp=%0d..%0d", n, TIMEOUT_CYC, TIMEOUT_CYC + 3); end
    checks++; if (status !== 3'd5) begin failures++; $display("FAIL to_status got=%0d exp=5", status); end
    checks++; if (change_amt !== AMT_W'(10)) begin failures++; $display("FAIL to_change got=%0d exp=10", change_amt); end
    checks++; if (dispense_valid !== 1'b0) begin failures++; $display("FAIL to_dispense got=%b exp=0", dispense_valid); end
    m_status = 5;
  endtask

  task automatic test_oos();
    do_select(5);
    checks++; if (status !== 3'd2) begin failures++; $display("FAIL oos_status got=%0d exp=2", status); end
    coin_in(2'b11);
    checks++; if (coin_reject !== 1'b1) begin failures++; $display("FAIL oos_idle_reject got=%b exp=1", coin_reject); end
    checks++; if (dispense_valid !== 1'b0 || amount !== '0) begin
      failures++; $display("FAIL oos_no_vend got=%b/%0d exp=0/0", dispense_valid, amount); end
    do_select(7);
    checks++; if (status !== 3'd3) begin failures++; $display("FAIL bad_sel_status got=%0d exp=3", status); end
    mark_status(3);
    do_restock(6, 1, 1'b0, 0);
    checks++; if (status !== 3'd3) begin failures++; $display("FAIL bad_rs_idx got=%0d exp=3", status); end
    m_status = 3;
  endtask

  task automatic test_restock_limits();
    void'(m_restock(1, 15, 1'b0, 0));
    do_restock(1, 15, 1'b0, 0);
    mark_status(1);
    checks++; if (price !== AMT_W'(DEF_COST)) begin failures++; $display("FAIL def_cost got=%0d exp=%0d", price, DEF_COST); end
    checks++; if (status !== 3'd4) begin failures++; $display("FAIL cancel_status got=%0d exp=4", status); end
    do_restock(1, 3, 1'b0, 0);
    checks++; if (status !== 3'd3) begin failures++; $display("FAIL over_ceiling got=%0d exp=3", status); end
    mark_status(1);
    do_restock(1, 1, 1'b0, 0);
    checks++; if (status !== 3'd4) begin failures++; $display("FAIL to_ceiling got=%0d exp=4", status); end
    do_restock(1, 0, 1'b0, 0);
    checks++; if (status !== 3'd4) begin failures++; $display("FAIL at_ceiling_zero got=%0d exp=4", status); end
    do_restock(1, 1, 1'b0, 0);
    checks++; if (status !== 3'd3) begin failures++; $display("FAIL past_ceiling got=%0d exp=3", status); end
    m_stock[1] = 16; m_status = 3;
  endtask

  task automatic test_cancel_reset();
    bit saw_chg = 1'b0;
    do_select(1);
    coin_in(2'b10);
    coin_valid = 1'b1; coin = 2'b01; cancel = 1'b1;
    tick();
    coin_valid = 1'b0; coin = 2'b00; cancel = 1'b0;
    checks++; if (status !== 3'd4) begin failures++; $display("FAIL cc_status got=%0d exp=4", status); end
    checks++; if (amount !== AMT_W'(15)) begin failures++; $display("FAIL cc_amount got=%0d exp=15", amount); end
    tick();
    checks++; if (change_valid !== 1'b1 || change_amt !== AMT_W'(15) || dispense_valid !== 1'b0) begin
      failures++; $display("FAIL cc_refund got=%b/%0d/%b exp=1/15/0", change_valid, change_amt, dispense_valid); end
    do_select(1);
    coin_in(2'b11);
    checks++; if (amount !== AMT_W'(25)) begin failures++; $display("FAIL rst_pre_amount got=%0d exp=25", amount); end
    #2 hrst_n = 1'b0;
    #1;
    checks++; if (amount !== '0 || status !== 3'd0) begin
      failures++; $display("FAIL rst_async got=%0d/%0d exp=0/0", amount, status); end
    @(posedge clk); #1 hrst_n = 1'b1;
    m_reset();
    for (int k = 0; k < 5; k++) begin tick(); if (change_valid) saw_chg = 1'b1; end
    checks++; if (saw_chg !== 1'b0) begin failures++; $display("FAIL rst_change_pulse got=1 exp=0"); end
    do_select(1);
    checks++; if (status !== 3'd2) begin failures++; $display("FAIL rst_stock_clear got=%0d exp=2", status); end
    m_status = 2;
  endtask

  task automatic test_random();
    int sum, idx, cnt, cst, code, n;
    bit cv, err;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, 7); cnt = $urandom_range(0, 6);
        cv = ($urandom_range(0, 1) == 1); cst = $urandom_range(1, 30) * 5;
        err = m_restock(idx, cnt, cv, cst);
        if (err) m_status = 3;
        do_restock(idx, cnt, cv, cst);
        checks++; if (status !== 3'(m_status)) begin
          failures++; $display("FAIL rnd_rs[%0d] idx=%0d cnt=%0d got=%0d exp=%0d", it, idx, cnt, status, m_status); end
      end else begin
        idx = $urandom_range(0, N_ITEMS - 1);
        do_select(idx);
        if (m_stock[idx] == 0) begin
          m_status = 2;
          checks++; if (status !== 3'd2) begin failures++; $display("FAIL rnd_oos[%0d] got=%0d exp=2", it, status); end
        end else begin
          m_status = 1;
          checks++; if (status !== 3'd1 || price !== AMT_W'(m_cost[idx])) begin
            failures++; $display("FAIL rnd_sel[%0d] got=%0d/%0d exp=1/%0d", it, status, price, m_cost[idx]); end
          sum = 0; n = 0;
          while (sum < m_cost[idx] && n < 300) begin
            code = $urandom_range(0, 3);
            coin_in(2'(code));
            sum += coin_value(code); n++;
            checks++; if (amount !== AMT_W'(sum)) begin
              failures++; $display("FAIL rnd_amount[%0d] got=%0d exp=%0d", it, amount, sum); end
            if (code == 0) begin
              checks++; if (coin_reject !== 1'b1) begin failures++; $display("FAIL rnd_reject[%0d] got=%b exp=1", it, coin_reject); end
            end
          end
          tick();
          checks++; if (dispense_valid !== 1'b1 || dispense_idx !== IDX_W'(idx)) begin
            failures++; $display("FAIL rnd_disp[%0d] got=%b/%0d exp=1/%0d", it, dispense_valid, dispense_idx, idx); end
          checks++; if (change_valid !== 1'b1 || change_amt !== AMT_W'(sum - m_cost[idx])) begin
            failures++; $display("FAIL rnd_change[%0d] got=%b/%0d exp=1/%0d", it, change_valid, change_amt, sum - m_cost[idx]); end
          m_stock[idx]--; exp_disp++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_restock_vend();
    test_overpay();
    test_timeout();
    test_oos();
    test_restock_limits();
    test_cancel_reset();
    test_random();
    tick();
    checks++; if (seen_disp !== exp_disp) begin failures++; $display("FAIL dispense_count got=%0d exp=%0d", seen_disp, exp_disp); end
    checks++; if (pulse_bad !== 0) begin failures++; $display("FAIL pulse_width got=%0d exp=0", pulse_bad); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
